hsid_sq_df_acc_lanes: RTL and testbench

HSID_SQ_DF_ACC_LANES -- requirements
Module: hsid_sq_df_acc_lanes

---
 rtl/hsid_pkg.sv | 16 +
 rtl/hsid_sq_df_lane.sv | 50 +++++
 rtl/hsid_sq_df_acc_lanes.sv | 190 +++++++++++++++++++
 tb/tb_hsid_sq_df_acc_lanes.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared constants and types for the HSID squared/absolute-difference datapath.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH      = 8;
  localparam int HSID_DATA_WIDTH_MUL  = 16;
  localparam int HSID_DATA_WIDTH_ACC  = 32;
  localparam int HSID_MAX_HSP_LIBRARY = 16;
  localparam int HSID_SQ_DF_LANES     = 4;
  localparam int HSID_SQ_DF_STAGES    = 3;

  typedef enum logic {
    SQ_DF_SQUARE = 1'b0,
    SQ_DF_ABS    = 1'b1
  } hsid_sq_df_mode_t;

endpackage

// File: rtl/hsid_sq_df_lane.sv
// One lane: S1 registers masked |a-b|, S2 registers its square or zero-extended value.
// Two-cycle latency; both registers hold while en_i is low.
module hsid_sq_df_lane
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HSID_DATA_WIDTH_MUL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  input  logic                      mask_i,
  input  hsid_sq_df_mode_t          mode_i,
  output logic [DATA_WIDTH_MUL-1:0] prod_o
);

  logic [DATA_WIDTH-1:0]     diff_d, diff_q;
  logic [DATA_WIDTH_MUL-1:0] prod_d, prod_q;

  always_comb begin
    diff_d = '0;
    if (mask_i) begin
      diff_d = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    end
  end

  // mode_i is the mode of the beat currently held in diff_q
  always_comb begin
    if (mode_i == SQ_DF_SQUARE) begin
      prod_d = DATA_WIDTH_MUL'(diff_q) * DATA_WIDTH_MUL'(diff_q);
    end else begin
      prod_d = DATA_WIDTH_MUL'(diff_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      prod_q <= '0;
    end else if (en_i) begin
      diff_q <= diff_d;
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/hsid_sq_df_acc_lanes.sv
// Multi-lane squared/absolute difference with per-vector running sum; 3-cycle latency, whole pipe stalls on !acc_ready.
// Define HSID_SQ_DF_ACC_SAT_EN to saturate the running sum and flag acc_overflow; otherwise the sum wraps.
module hsid_sq_df_acc_lanes
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HSID_DATA_WIDTH_MUL,
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC,
  parameter int LANES          = HSID_SQ_DF_LANES,
  parameter int REF_WIDTH      = $clog2(HSID_MAX_HSP_LIBRARY)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        initial_acc_en,
  input  logic [DATA_WIDTH_ACC-1:0]   initial_acc,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        data_in_last,
  input  logic [REF_WIDTH-1:0]        data_in_ref,
  input  logic [LANES*DATA_WIDTH-1:0] data_in_a,
  input  logic [LANES*DATA_WIDTH-1:0] data_in_b,
  input  logic [LANES-1:0]            data_in_mask,
  input  hsid_sq_df_mode_t            data_in_mode,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic [DATA_WIDTH_ACC-1:0]   acc_value,
  output logic                        acc_last,
  output logic [REF_WIDTH-1:0]        acc_ref,
  output logic                        acc_overflow
);

  localparam int SUM_W = DATA_WIDTH_MUL + $clog2(LANES);

  typedef struct packed {
    logic                      last;
    logic [REF_WIDTH-1:0]      tag;
    logic                      first;
    logic [DATA_WIDTH_ACC-1:0] start;
  } beat_meta_t;

  logic                      en, accept;
  logic                      first_q, first_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH_ACC-1:0] pend_val_q, pend_val_d;
  beat_meta_t                in_meta, s1_meta_q, s2_meta_q;
  logic                      s1_vld_q, s2_vld_q;
  hsid_sq_df_mode_t          s1_mode_q;
  logic [DATA_WIDTH_MUL-1:0] lane_prod [LANES];
  logic [SUM_W-1:0]          tree_sum;
  logic [DATA_WIDTH_ACC-1:0] tree_acc, base, acc_value_d;
  logic                      acc_valid_q, acc_last_q;
  logic [DATA_WIDTH_ACC-1:0] acc_value_q;
  logic [REF_WIDTH-1:0]      acc_ref_q;

  assign en            = !acc_valid_q || acc_ready;
  assign data_in_ready = en;
  assign accept        = data_in_valid && en;

  // A load in the same cycle as consumption survives for the following vector
  always_comb begin
    first_d    = first_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    if (accept) begin
      first_d = data_in_last;
      if (first_q) pend_vld_d = 1'b0;
    end
    if (initial_acc_en) begin
      pend_vld_d = 1'b1;
      pend_val_d = initial_acc;
    end
  end

  always_comb begin
    in_meta = '{last: data_in_last, tag: data_in_ref, first: first_q,
                start: (pend_vld_q ? pend_val_q : '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      first_q    <= first_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_meta_q <= '0;
      s2_meta_q <= '0;
      s1_mode_q <= SQ_DF_SQUARE;
    end else if (en) begin
      s1_vld_q  <= data_in_valid;
      s1_meta_q <= in_meta;
      s1_mode_q <= data_in_mode;
      s2_vld_q  <= s1_vld_q;
      s2_meta_q <= s1_meta_q;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    hsid_sq_df_lane #(
      .DATA_WIDTH     (DATA_WIDTH),
      .DATA_WIDTH_MUL (DATA_WIDTH_MUL)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .a_i    (data_in_a[gi*DATA_WIDTH +: DATA_WIDTH]),
      .b_i    (data_in_b[gi*DATA_WIDTH +: DATA_WIDTH]),
      .mask_i (data_in_mask[gi]),
      .mode_i (s1_mode_q),
      .prod_o (lane_prod[gi])
    );
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(lane_prod[i]);
    end
    tree_acc = DATA_WIDTH_ACC'(tree_sum);
  end

  // acc_value_q doubles as the running sum between beats of a vector
`ifdef HSID_SQ_DF_ACC_SAT_EN
  logic [DATA_WIDTH_ACC:0] sum_ext;
  logic                    acc_ovf_q, acc_ovf_d;

  always_comb begin
    base        = s2_meta_q.first ? s2_meta_q.start : acc_value_q;
    sum_ext     = {1'b0, base} + {1'b0, tree_acc};
    acc_value_d = sum_ext[DATA_WIDTH_ACC] ? '1 : sum_ext[DATA_WIDTH_ACC-1:0];
  end

  always_comb begin
    acc_ovf_d = acc_ovf_q;
    if (s2_vld_q) begin
      acc_ovf_d = (!s2_meta_q.first && acc_ovf_q) || sum_ext[DATA_WIDTH_ACC];
    end else if (acc_valid_q && acc_last_q) begin
      acc_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_ovf_q <= 1'b0;
    end else if (en) begin
      acc_ovf_q <= acc_ovf_d;
    end
  end

  assign acc_overflow = acc_ovf_q;
`else
  always_comb begin
    base        = s2_meta_q.first ? s2_meta_q.start : acc_value_q;
    acc_value_d = base + tree_acc;
  end

  assign acc_overflow = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid_q <= 1'b0;
      acc_value_q <= '0;
      acc_last_q  <= 1'b0;
      acc_ref_q   <= '0;
    end else if (en) begin
      acc_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        acc_value_q <= acc_value_d;
        acc_last_q  <= s2_meta_q.last;
        acc_ref_q   <= s2_meta_q.tag;
      end
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_value = acc_value_q;
  assign acc_last  = acc_last_q;
  assign acc_ref   = acc_ref_q;

endmodule

// File: tb/tb_hsid_sq_df_acc_lanes.sv
// Randomised bench for hsid_sq_df_acc_lanes with a vector-level reference model (DATA_WIDTH_ACC=16).
`timescale 1ns/1ps
module tb_hsid_sq_df_acc_lanes;
  import hsid_pkg::*;

  localparam int DW = 8;
  localparam int MW = 16;
  localparam int AW = 16;
  localparam int LN = 4;
  localparam int RW = 4;
  localparam longint AMOD = 65536;

  logic             clk = 1'b0;
  logic             rst;
  logic             initial_acc_en;
  logic [AW-1:0]    initial_acc;
  logic             data_in_valid, data_in_ready, data_in_last;
  logic [RW-1:0]    data_in_ref;
  logic [LN*DW-1:0] data_in_a, data_in_b;
  logic [LN-1:0]    data_in_mask;
  hsid_sq_df_mode_t data_in_mode;
  logic             acc_valid, acc_ready, acc_last, acc_overflow;
  logic [AW-1:0]    acc_value;
  logic [RW-1:0]    acc_ref;

  always #5 clk = ~clk;

  hsid_sq_df_acc_lanes #(
    .DATA_WIDTH(DW), .DATA_WIDTH_MUL(MW), .DATA_WIDTH_ACC(AW), .LANES(LN), .REF_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .initial_acc_en(initial_acc_en), .initial_acc(initial_acc),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in_last(data_in_last),
    .data_in_ref(data_in_ref), .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_in_mask(data_in_mask), .data_in_mode(data_in_mode),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_value(acc_value),
    .acc_last(acc_last), .acc_ref(acc_ref), .acc_overflow(acc_overflow)
  );

  typedef struct packed {
    logic [AW-1:0] value;
    logic          last;
    logic [RW-1:0] tag;
    logic          ovf;
  } res_t;

  res_t   exp_q[$];
  res_t   got_q[$];
  int     errors = 0;
  int     checks = 0;
  bit     m_first = 1'b1, m_pend_vld = 1'b0, m_ovf = 1'b0;
  longint m_pend = 0, m_sum = 0;
  bit     rdy_rand = 1'b0, rdy_hold0 = 1'b0;

  // Vector-level model: running sum of per-beat lane contributions
  function automatic void model_accept();
    longint x = 0;
    int     av, bv, d;
    res_t   r;
    for (int i = 0; i < LN; i++) begin
      if (data_in_mask[i]) begin
        av = int'(data_in_a[i*DW +: DW]);
        bv = int'(data_in_b[i*DW +: DW]);
        d  = (av > bv) ? av - bv : bv - av;
        x  = x + ((data_in_mode == SQ_DF_ABS) ? longint'(d) : longint'(d * d));
      end
    end
    x = x % AMOD;
    if (m_first) begin
      m_sum      = m_pend_vld ? m_pend : 0;
      m_pend_vld = 1'b0;
      m_ovf      = 1'b0;
    end
    m_sum = m_sum + x;
`ifdef HSID_SQ_DF_ACC_SAT_EN
    if (m_sum > AMOD - 1) begin
      m_sum = AMOD - 1;
      m_ovf = 1'b1;
    end
`else
    m_sum = m_sum % AMOD;
    m_ovf = 1'b0;
`endif
    m_first = data_in_last;
    r.value = m_sum[AW-1:0];
    r.last  = data_in_last;
    r.tag   = data_in_ref;
    r.ovf   = m_ovf;
    exp_q.push_back(r);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_first = 1'b1; m_pend_vld = 1'b0; m_sum = 0; m_ovf = 1'b0;
    end else begin
      if (data_in_valid && data_in_ready) model_accept();
      if (initial_acc_en) begin
        m_pend_vld = 1'b1;
        m_pend     = longint'(initial_acc);
      end
      if (acc_valid && acc_ready) got_q.push_back('{acc_value, acc_last, acc_ref, acc_overflow});
    end
  end

  initial begin
    acc_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      acc_ready = rdy_hold0 ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic send_beat(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b,
                           input logic [LN-1:0] m, input bit md, input bit last,
                           input logic [RW-1:0] tg, input int gap, input bit ld,
                           input logic [AW-1:0] ldv);
    int t = 0;
    data_in_a = a; data_in_b = b; data_in_mask = m; data_in_last = last; data_in_ref = tg;
    data_in_mode = md ? SQ_DF_ABS : SQ_DF_SQUARE;
    data_in_valid = 1'b1; initial_acc_en = ld; initial_acc = ldv;
    @(negedge clk);
    while (!data_in_ready && t < 200) begin
      @(posedge clk); #1; initial_acc_en = 1'b0;
      @(negedge clk); t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL send_timeout: data_in_ready=%0b, expected 1 within 200 cycles", data_in_ready);
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0; initial_acc_en = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 500) begin @(negedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; initial_acc_en = 1'b0; initial_acc = '0; data_in_valid = 1'b0;
    data_in_last = 1'b0; data_in_ref = '0; data_in_a = '0; data_in_b = '0;
    data_in_mask = '0; data_in_mode = SQ_DF_SQUARE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", data_in_ready); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", acc_valid); end
    checks++; if (acc_value !== '0 || acc_ref !== '0) begin errors++; $display("FAIL rst_value: got %0d ref %0d want 0 0", acc_value, acc_ref); end
    checks++; if (acc_last !== 1'b0 || acc_overflow !== 1'b0) begin errors++; $display("FAIL rst_flags: last %0b ovf %0b want 0 0", acc_last, acc_overflow); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", data_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat = 0;
    initial_acc_en = 1'b1; initial_acc = 16'd10;
    @(posedge clk); #1; initial_acc_en = 1'b0;
    data_in_a = {8'd4, 8'd3, 8'd2, 8'd1}; data_in_b = {4{8'd4}}; data_in_mask = 4'b1111;
    data_in_mode = SQ_DF_SQUARE; data_in_last = 1'b1; data_in_ref = 4'd2; data_in_valid = 1'b1;
    @(negedge clk);
    while (lat < 10) begin
      @(posedge clk); #1; data_in_valid = 1'b0;
      @(negedge clk); lat++;
      if (acc_valid) break;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
    drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i, got_q[i].value, got_q[i].last, got_q[i].tag, got_q[i].ovf, exp_q[i].value, exp_q[i].last, exp_q[i].tag, exp_q[i].ovf); end
    end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].value !== 16'd24 || got_q[0].last !== 1'b1) begin errors++; $display("FAIL basic_value: got %0d last %0b want 24 last 1", got_q[0].value, got_q[0].last); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_two_beat();
    for (int md = 0; md < 2; md++) begin
      send_beat({4{8'd5}}, {4{8'd0}}, 4'b0011, md[0], 1'b0, 4'd1, 0, 1'b0, '0);
      send_beat({4{8'd5}}, {4{8'd0}}, 4'b1000, md[0], 1'b1, 4'd1, 0, 1'b0, '0);
      drain();
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL two_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_beat%0d: got %0d/%0b/%0d want %0d/%0b/%0d", i, got_q[i].value, got_q[i].last, got_q[i].tag, exp_q[i].value, exp_q[i].last, exp_q[i].tag); end
      end
      if (got_q.size() >= 2) begin
        checks++; if (got_q[0].value !== (md ? 16'd10 : 16'd50)) begin errors++; $display("FAIL two_first: got %0d want %0d", got_q[0].value, md ? 10 : 50); end
        checks++; if (got_q[1].value !== (md ? 16'd15 : 16'd75)) begin errors++; $display("FAIL two_second: got %0d want %0d", got_q[1].value, md ? 15 : 75); end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_stall();
    send_beat($urandom, $urandom, 4'b1111, 1'b0, 1'b0, 4'd3, 0, 1'b0, '0);
    send_beat($urandom, $urandom, 4'b0110, 1'b1, 1'b0, 4'd3, 0, 1'b0, '0);
    rdy_hold0 = 1'b1;
    fork
      send_beat($urandom, $urandom, 4'b1011, 1'b0, 1'b0, 4'd3, 0, 1'b0, '0);
      begin
        for (int t = 0; t < 20; t++) begin @(negedge clk); if (!data_in_ready) break; end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", data_in_ready); end
        end
        checks++;
        if (exp_q.size() <= got_q.size() || acc_valid !== 1'b1 || acc_value !== exp_q[got_q.size()].value) begin
          errors++; $display("FAIL stall_hold: valid %0b value %0d, expected held model value", acc_valid, acc_value);
        end
        @(posedge clk); #1; rdy_hold0 = 1'b0;
      end
    join
    send_beat($urandom, $urandom, 4'b1111, 1'b1, 1'b1, 4'd3, 0, 1'b0, '0);
    drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %0d/%0b/%0d want %0d/%0b/%0d", i, got_q[i].value, got_q[i].last, got_q[i].tag, exp_q[i].value, exp_q[i].last, exp_q[i].tag); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sat();
    logic [AW-1:0] want_v;
    logic          want_o;
`ifdef HSID_SQ_DF_ACC_SAT_EN
    want_v = 16'd65535; want_o = 1'b1;
`else
    want_v = 16'd63492; want_o = 1'b0;
`endif
    send_beat({4{8'd255}}, {4{8'd0}}, 4'b0011, 1'b0, 1'b0, 4'd5, 0, 1'b0, '0);
    send_beat({4{8'd255}}, {4{8'd0}}, 4'b0011, 1'b0, 1'b1, 4'd5, 0, 1'b0, '0);
    drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_beat%0d: got %0d ovf %0b want %0d ovf %0b", i, got_q[i].value, got_q[i].ovf, exp_q[i].value, exp_q[i].ovf); end
    end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[1].value !== want_v || got_q[1].ovf !== want_o) begin errors++; $display("FAIL sat_final: got %0d ovf %0b want %0d ovf %0b", got_q[1].value, got_q[1].ovf, want_v, want_o); end
      checks++; if (got_q[0].ovf !== 1'b0) begin errors++; $display("FAIL sat_first_ovf: got %0b want 0", got_q[0].ovf); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send_beat($urandom, $urandom, 4'b1111, 1'b0, 1'b0, 4'd6, 0, 1'b0, '0);
    send_beat($urandom, $urandom, 4'b1111, 1'b0, 1'b0, 4'd6, 0, 1'b0, '0);
    for (int t = 0; t < 10; t++) begin @(negedge clk); if (acc_valid) break; end
    #1 rst = 1'b1;
    #1;
    checks++; if (acc_valid !== 1'b0 || acc_value !== '0) begin errors++; $display("FAIL async_rst: valid %0b value %0d want 0 0", acc_valid, acc_value); end
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b want 1", data_in_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete(); exp_q.delete();
    send_beat({4{8'd1}}, {4{8'd0}}, 4'b1111, 1'b0, 1'b1, 4'd9, 0, 1'b0, '0);
    drain();
    checks++; if (got_q.size() !== 1 || exp_q.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_model: got %0d ref %0d want %0d ref %0d", got_q[0].value, got_q[0].tag, exp_q[0].value, exp_q[0].tag); end
      checks++; if (got_q[0].value !== 16'd4 || got_q[0].tag !== 4'd9) begin errors++; $display("FAIL rstmid_value: got %0d ref %0d want 4 ref 9", got_q[0].value, got_q[0].tag); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int nb;
    rdy_rand = 1'b1;
    for (int v = 0; v < 3; v++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        send_beat($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  (k == nb - 1), 4'(v), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                  16'($urandom_range(0, 5000)));
      end
    end
    rdy_rand = 1'b0;
    drain();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %0d/%0b/%0d/%0b want %0d/%0b/%0d/%0b", i, got_q[i].value, got_q[i].last, got_q[i].tag, got_q[i].ovf, exp_q[i].value, exp_q[i].last, exp_q[i].tag, exp_q[i].ovf); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_beat();
    test_stall();
    test_sat();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
